// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader: FSM encoding, default line rate, idle level.
// The LOADER_PARITY_EN macro enables the even-parity bit; this package is the same with or without it.
package uart_program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } loader_state_e;

    localparam int   DEF_CLK_FREQ_HZ = 50000000;
    localparam int   DEF_BAUD        = 115200;
    localparam logic LINE_IDLE       = 1'b1;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin plus a previous-value register
// used for start-edge detection. All flops reset to the line idle level.
module uart_rx_sync
    import uart_program_loader_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic rx_async,
    output logic rx_s,
    output logic fall_edge
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic rx_p_q,  rx_p_d;

    // Next-state values for the synchronizer chain.
    always_comb begin
        sync1_d = rx_async;
        sync2_d = sync1_q;
        rx_p_d  = sync2_q;
    end

    // Synchronizer and previous-value registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= LINE_IDLE;
            sync2_q <= LINE_IDLE;
            rx_p_q  <= LINE_IDLE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            rx_p_q  <= rx_p_d;
        end
    end

    assign rx_s      = sync2_q;
    assign fall_edge = rx_p_q & ~sync2_q;

endmodule

// File: rtl/uart_program_loader.sv
// UART receiver feeding the instruction-memory byte stream; delivery is gated by execution_enable.
// Define LOADER_PARITY_EN for 8E1 framing with a sticky parity_error flag; otherwise 8N1.
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = DEF_CLK_FREQ_HZ,
    parameter int BAUD         = DEF_BAUD,
    parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        uart_rx,
    input  logic        execution_enable,
    output logic        PC_data_valid,
    output logic [7:0]  PC_data,
    output logic [31:0] byte_count,
    output logic        frame_error,
    output logic        parity_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic rx_s;
    logic fall_edge;

    loader_state_e    state_q,         state_d;
    logic [CNT_W-1:0] clk_cnt_q,       clk_cnt_d;
    logic [2:0]       bit_idx_q,       bit_idx_d;
    logic [7:0]       shift_q,         shift_d;
    logic             accept_q,        accept_d;
    logic             pc_data_valid_q, pc_data_valid_d;
    logic [7:0]       pc_data_q,       pc_data_d;
    logic [31:0]      byte_count_q,    byte_count_d;
    logic             frame_error_q,   frame_error_d;
`ifdef LOADER_PARITY_EN
    logic             parity_error_q,  parity_error_d;
    logic             par_bad_q,       par_bad_d;
`endif

    uart_rx_sync u_rx_sync (
        .clk       (SYS_clk),
        .reset     (SYS_reset),
        .rx_async  (uart_rx),
        .rx_s      (rx_s),
        .fall_edge (fall_edge)
    );

    // Frame decoding FSM and delivery logic.
    always_comb begin
        state_d         = state_q;
        clk_cnt_d       = clk_cnt_q;
        bit_idx_d       = bit_idx_q;
        shift_d         = shift_q;
        accept_d        = 1'b0;
        pc_data_valid_d = 1'b0;
        pc_data_d       = pc_data_q;
        byte_count_d    = byte_count_q;
        frame_error_d   = frame_error_q;
`ifdef LOADER_PARITY_EN
        parity_error_d  = parity_error_q;
        par_bad_d       = par_bad_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (fall_edge) begin
                    state_d   = ST_START;
                    clk_cnt_d = '0;
                    bit_idx_d = 3'd0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    if (!rx_s) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef LOADER_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
`ifdef LOADER_PARITY_EN
            ST_PARITY: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    state_d   = ST_STOP;
                    par_bad_d = (rx_s != even_parity(shift_q));
                    if (rx_s != even_parity(shift_q)) begin
                        parity_error_d = 1'b1;
                    end else begin
                        parity_error_d = parity_error_q;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    state_d   = ST_IDLE;
                    if (rx_s) begin
`ifdef LOADER_PARITY_EN
                        accept_d = ~par_bad_q;
`else
                        accept_d = 1'b1;
`endif
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Byte accepted on the previous edge: hand it over unless execution has started.
        if (accept_q) begin
            if (!execution_enable) begin
                pc_data_valid_d = 1'b1;
                pc_data_d       = shift_q;
                byte_count_d    = byte_count_q + 32'd1;
            end else begin
                pc_data_valid_d = 1'b0;
            end
        end else begin
            pc_data_valid_d = 1'b0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_q         <= ST_IDLE;
            clk_cnt_q       <= '0;
            bit_idx_q       <= 3'd0;
            shift_q         <= 8'd0;
            accept_q        <= 1'b0;
            pc_data_valid_q <= 1'b0;
            pc_data_q       <= 8'd0;
            byte_count_q    <= 32'd0;
            frame_error_q   <= 1'b0;
`ifdef LOADER_PARITY_EN
            parity_error_q  <= 1'b0;
            par_bad_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            clk_cnt_q       <= clk_cnt_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            accept_q        <= accept_d;
            pc_data_valid_q <= pc_data_valid_d;
            pc_data_q       <= pc_data_d;
            byte_count_q    <= byte_count_d;
            frame_error_q   <= frame_error_d;
`ifdef LOADER_PARITY_EN
            parity_error_q  <= parity_error_d;
            par_bad_q       <= par_bad_d;
`endif
        end
    end

    assign PC_data_valid = pc_data_valid_q;
    assign PC_data       = pc_data_q;
    assign byte_count    = byte_count_q;
    assign frame_error   = frame_error_q;
`ifdef LOADER_PARITY_EN
    assign parity_error  = parity_error_q;
`else
    assign parity_error  = 1'b0;
`endif

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Serial-to-byte front end for instruction loading: receives 8N1 UART frames from the host and drives the byte-stream write interface (PC_data_valid / PC_data) consumed by the instruction memory.
- Delivery stops once the core reports execution_enable=1; the line is still decoded and errors are still flagged.
- Sits between the board RX pin and the instruction memory.

Parameters:
- CLK_FREQ_HZ, 50000000, SYS_clk frequency.
- BAUD, 115200, line rate.
- CLKS_PER_BIT, CLK_FREQ_HZ/BAUD (integer divide), SYS_clk cycles per bit. Must be ≥4.

Ports:
- SYS_clk  in  1  system clock.
- SYS_reset  in  1  synchronous, active-high reset.
- uart_rx  in  1  serial line, idle high, asynchronous to SYS_clk.
- execution_enable  in  1  from instruction memory; 1 blocks delivery.
- PC_data_valid  out  1  one-cycle strobe, byte on PC_data.
- PC_data  out  8  received byte, held until next delivery.
- byte_count  out  32  bytes delivered since reset.
- frame_error  out  1  sticky, stop bit sampled low.
- parity_error  out  1  sticky, parity mismatch (tied 0 without LOADER_PARITY_EN).

Behaviour:
- Reset values (one SYS_clk edge with SYS_reset=1):
  - All outputs 0.
  - Both synchronizer flops 1.
  - State IDLE; counters 0.
  - Reset mid-frame abandons the frame; no strobe.
- uart_rx passes through a 2-flop synchronizer. All decisions use the synchronized value rx_s and its previous value rx_p.
- States and transitions:
  - IDLE → START on falling edge (rx_p=1, rx_s=0). Bit counter and cycle counter cleared.
  - START: count to CLKS_PER_BIT/2−1.
    - If rx_s=0 at that point → DATA with cycle counter cleared.
    - Otherwise (glitch) → IDLE.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first, bit index 0..7. After the bit-7 sample → STOP (or PARITY).
  - STOP: sample after CLKS_PER_BIT cycles.
    - rx_s=1 and no parity error: byte accepted.
    - rx_s=0: frame_error←1, byte dropped.
    - Either case → IDLE.
- Accepted byte, with execution_enable=0:
  - On the next edge: PC_data←byte, PC_data_valid=1 for exactly one cycle, byte_count+1.
  - Latency: strobe is 1 cycle after the stop-bit sample edge.
- Accepted byte, with execution_enable=1: no strobe, PC_data and byte_count unchanged.
- byte_count wraps modulo 2^32.
- Error flags: frame_error and parity_error clear only on reset.
- Line held low (break): after a frame error, IDLE waits for a fresh falling edge, so a break yields exactly one frame error.
- Back-to-back frames: a start edge arriving in the same cycle the FSM returns to IDLE is still detected, because rx_p is tracked in every state.
- Simultaneous events: execution_enable rising in the same cycle as byte acceptance suppresses that byte. The registered value is sampled at the accept edge.

Optional Feature:
- LOADER_PARITY_EN defined:
  - Adds a PARITY state between DATA and STOP that samples one even-parity bit.
  - Mismatch sets parity_error and drops the byte; the stop bit is still checked.
- LOADER_PARITY_EN undefined:
  - 8N1 only, no PARITY state.
  - parity_error is a constant 0.

Decomposition:
- Shared include (alongside the existing system include):
  - FSM state encodings: IDLE, START, DATA, PARITY, STOP.
  - Default CLK_FREQ_HZ / BAUD.
  - Line idle level.
- Natural sub-module: uart_rx_sync. It is the 2-flop synchronizer plus the rx_p register, outputs rx_s and fall_edge, and is reset to 1 synchronously.

Test Plan:
- Bench setup for all scenarios: CLK_FREQ_HZ=1000, BAUD=100, so CLKS_PER_BIT=10.
- Send 0xA5 with execution_enable=0 → exactly one PC_data_valid pulse, PC_data=0xA5, byte_count=1, strobe 1 cycle after the stop-bit sample.
- Send 0x13, 0x00, 0xFF back-to-back with no idle gap → three strobes in order with data 0x13, 0x00, 0xFF; byte_count=3; frame_error=0.
- 3-cycle low glitch on idle line → return to IDLE; no strobe; no error.
- Frame 0x55 with stop bit low → frame_error=1 sticky, no strobe, byte_count unchanged. Next good frame 0x01 is delivered.
- Set execution_enable=1, send 0x7E → no strobe; PC_data and byte_count hold their previous values.
- Assert SYS_reset mid-DATA at bit 4, then send 0x3C → all outputs 0 after reset; only 0x3C is delivered. With LOADER_PARITY_EN, a wrong parity bit gives parity_error=1 and no strobe.
